// File: rtl/btn_pkg.sv
// Shared types and width helpers for the debounced button input stage.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } btn_state_e;

    // Bits needed to hold 0..max_val inclusive; never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_chan.sv
// One debounced button channel: sample history, stable level and typematic repeat FSM.
module btn_chan
    import btn_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned RPT_DLY = 20,
    parameter int unsigned RPT_PER = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic p,
    input  logic rpt_en,
    output logic bout,
    output logic brel,
    output logic lvl_next
);

    localparam int unsigned RC_W = cnt_width(max2(RPT_DLY, RPT_PER));
    localparam logic [RC_W-1:0] DLY_MAX  = RC_W'(RPT_DLY);
    localparam logic [RC_W-1:0] DLY_LAST = RC_W'(RPT_DLY - 1);
    localparam logic [RC_W-1:0] PER_MAX  = RC_W'(RPT_PER);
    localparam logic [RC_W-1:0] PER_LAST = RC_W'(RPT_PER - 1);

    logic [DEPTH-1:0] hist_q, hist_d, hist_shift;
    logic             lvl_q, lvl_d;
    btn_state_e       state_q, state_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic             press_ev, rel_ev;

    // Oldest sample falls off the top; works for DEPTH == 1 as well.
    assign hist_shift = DEPTH'({hist_q, p});
    assign hist_d     = tick ? hist_shift : hist_q;
    assign press_ev   = tick & (&hist_shift) & ~lvl_q;
    assign rel_ev     = tick & ~(|hist_shift) & lvl_q;
    assign lvl_d      = press_ev ? 1'b1 : (rel_ev ? 1'b0 : lvl_q);
    assign lvl_next   = lvl_d;

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        bout    = 1'b0;
        brel    = 1'b0;
        if (rel_ev) begin
            // Release wins over any repeat due on the same tick.
            brel    = 1'b1;
            state_d = IDLE;
            rc_d    = '0;
        end else if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (press_ev) begin
                        bout    = 1'b1;
                        rc_d    = '0;
                        state_d = DELAY;
                    end
                end
                DELAY: begin
                    if (rc_q >= DLY_LAST) begin
                        if (rpt_en) begin
                            bout    = 1'b1;
                            rc_d    = '0;
                            state_d = REPEAT;
                        end else begin
                            rc_d = DLY_MAX;
                        end
                    end else begin
                        rc_d = rc_q + RC_W'(1);
                    end
                end
                REPEAT: begin
                    if (rc_q >= PER_LAST) begin
                        if (rpt_en) begin
                            bout = 1'b1;
                            rc_d = '0;
                        end else begin
                            rc_d = PER_MAX;
                        end
                    end else begin
                        rc_d = rc_q + RC_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    rc_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q  <= '0;
            lvl_q   <= 1'b0;
            state_q <= IDLE;
            rc_q    <= '0;
        end else begin
            hist_q  <= hist_d;
            lvl_q   <= lvl_d;
            state_q <= state_d;
            rc_q    <= rc_d;
        end
    end

endmodule

// File: rtl/btn_in_rpt.sv
// Front-panel button input stage: tick generator, polarity normalisation and N_CH
// debounced channels with press/release/repeat pulses registered onto the outputs.
module btn_in_rpt
    import btn_pkg::*;
#(
    parameter int unsigned N_CH       = 7,
    parameter int unsigned TICK_DIV   = 1250000,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned RPT_DLY    = 20,
    parameter int unsigned RPT_PER    = 4,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] nBIN,
    input  logic [N_CH-1:0] RPT_EN,
    output logic [N_CH-1:0] BOUT,
    output logic [N_CH-1:0] BREL,
    output logic [N_CH-1:0] BLVL
);

    localparam int unsigned CNT_W = cnt_width(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             tick;
    logic [N_CH-1:0]  p_q;
    logic [N_CH-1:0]  bout_d, brel_d, lvl_d;

    assign tick = (cnt_q == CNT_LAST);

    // p_q registers the asynchronous pins once, already normalised to 1 = pressed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
            p_q   <= '0;
            BOUT  <= '0;
            BREL  <= '0;
            BLVL  <= '0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
            p_q   <= ACTIVE_LOW ? ~nBIN : nBIN;
            BOUT  <= bout_d;
            BREL  <= brel_d;
            BLVL  <= lvl_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        btn_chan #(
            .DEPTH   (DEPTH),
            .RPT_DLY (RPT_DLY),
            .RPT_PER (RPT_PER)
        ) u_chan (
            .clk      (CLK),
            .rst      (RST),
            .tick     (tick),
            .p        (p_q[i]),
            .rpt_en   (RPT_EN[i]),
            .bout     (bout_d[i]),
            .brel     (brel_d[i]),
            .lvl_next (lvl_d[i])
        );
    end

endmodule

// File: tb/tb_btn_in_rpt.sv
// Bench for btn_in_rpt: cycle scoreboard against a run-length reference model plus
// scenario tasks with explicit timing checks, and a TICK_DIV=1 / DEPTH=1 corner instance.
module tb_btn_in_rpt;

    localparam int NC = 3;
    localparam int TD = 4;
    localparam int DP = 2;
    localparam int RD = 3;
    localparam int RP = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] nbin, rpt_en, bout, brel, blvl;
    logic [NC-1:0] nbin1, rpt_en1, bout1, brel1, blvl1;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    btn_in_rpt #(
        .N_CH(NC), .TICK_DIV(TD), .DEPTH(DP), .RPT_DLY(RD), .RPT_PER(RP), .ACTIVE_LOW(1'b1)
    ) dut (
        .CLK(clk), .RST(rst), .nBIN(nbin), .RPT_EN(rpt_en), .BOUT(bout), .BREL(brel), .BLVL(blvl)
    );

    btn_in_rpt #(
        .N_CH(NC), .TICK_DIV(1), .DEPTH(1), .RPT_DLY(RD), .RPT_PER(RP), .ACTIVE_LOW(1'b1)
    ) dut1 (
        .CLK(clk), .RST(rst), .nBIN(nbin1), .RPT_EN(rpt_en1), .BOUT(bout1), .BREL(brel1),
        .BLVL(blvl1)
    );

    // Reference model: debounce by run length of identical samples, repeat by ticks elapsed.
    typedef struct packed {
        logic [NC-1:0] b;
        logic [NC-1:0] r;
        logic [NC-1:0] l;
    } exp_t;

    exp_t sb_q[$];
    int   m_cnt;
    bit   m_tk;
    int   m_lim;
    bit   m_p[NC];
    bit   m_rv[NC];
    int   m_rl[NC];
    bit   m_lvl[NC];
    int   m_st[NC];
    int   m_since[NC];

    always @(posedge clk) begin
        exp_t e;
        e = '0;
        if (rst) begin
            m_cnt = 0;
            for (int i = 0; i < NC; i++) begin
                m_p[i] = 0; m_rv[i] = 0; m_rl[i] = DP; m_lvl[i] = 0; m_st[i] = 0;
                m_since[i] = 0;
            end
        end else begin
            m_tk  = (m_cnt == TD - 1);
            m_cnt = m_tk ? 0 : m_cnt + 1;
            for (int i = 0; i < NC; i++) begin
                if (m_tk) begin
                    if (m_p[i] == m_rv[i]) m_rl[i] = (m_rl[i] < DP) ? m_rl[i] + 1 : DP;
                    else begin m_rv[i] = m_p[i]; m_rl[i] = 1; end
                    if (m_rv[i] && m_rl[i] >= DP && !m_lvl[i]) begin
                        m_lvl[i] = 1; e.b[i] = 1'b1; m_st[i] = 1; m_since[i] = 0;
                    end else if (!m_rv[i] && m_rl[i] >= DP && m_lvl[i]) begin
                        m_lvl[i] = 0; e.r[i] = 1'b1; m_st[i] = 0; m_since[i] = 0;
                    end else if (m_st[i] != 0) begin
                        m_since[i]++;
                        m_lim = (m_st[i] == 1) ? RD : RP;
                        if (m_since[i] >= m_lim) begin
                            if (rpt_en[i]) begin
                                e.b[i] = 1'b1; m_st[i] = 2; m_since[i] = 0;
                            end else begin
                                m_since[i] = m_lim;
                            end
                        end
                    end
                end
                m_p[i] = ~nbin[i];
                e.l[i] = m_lvl[i];
            end
        end
        sb_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            vectors++;
            if ({bout, brel, blvl} !== {e.b, e.r, e.l}) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t got b=%b r=%b l=%b expected b=%b r=%b l=%b",
                         $time, bout, brel, blvl, e.b, e.r, e.l);
            end
        end
    end

    task automatic test_reset;
        int bad;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bout, brel, blvl, bout1, brel1, blvl1} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %b required 0",
                     {bout, brel, blvl, bout1, brel1, blvl1});
        end
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ({bout, brel, blvl} !== '0) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL idle_quiet got %0d active cycles required 0", bad);
        end
    endtask

    task automatic test_clean_press;
        int n_hi, at;
        logic lvl_at, lvl_before, prev;
        @(negedge clk);
        nbin[0] = 1'b0;
        n_hi = 0; at = -1; lvl_at = 1'b0; lvl_before = 1'b1; prev = blvl[0];
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bout[0] === 1'b1) begin
                n_hi++;
                if (at < 0) begin at = k; lvl_at = blvl[0]; lvl_before = prev; end
            end
            prev = blvl[0];
        end
        vectors++;
        if (n_hi !== 1) begin
            miscompares++; $display("FAIL press_once got %0d high cycles required 1", n_hi);
        end
        vectors++;
        if (at < 6 || at > 9) begin
            miscompares++; $display("FAIL press_latency got %0d cycles required 6..9", at);
        end
        vectors++;
        if ({lvl_before, lvl_at} !== 2'b01) begin
            miscompares++;
            $display("FAIL press_blvl got before/at=%b required 01", {lvl_before, lvl_at});
        end
        @(negedge clk);
        nbin[0] = 1'b1;
        n_hi = 0; at = -1; lvl_at = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bout[0] === 1'b1) n_hi += 100;
            if (brel[0] === 1'b1) begin
                n_hi++;
                if (at < 0) begin at = k; lvl_at = blvl[0]; end
            end
        end
        vectors++;
        if (n_hi !== 1) begin
            miscompares++; $display("FAIL release_once got %0d required 1", n_hi);
        end
        vectors++;
        if (at < 6 || at > 9 || lvl_at !== 1'b0) begin
            miscompares++;
            $display("FAIL release_timing got at=%0d blvl=%b required 6..9 and 0", at, lvl_at);
        end
    endtask

    task automatic test_glitch;
        int bad;
        bad = 0;
        @(negedge clk);
        nbin[1] = 1'b0;
        for (int k = 0; k < TD; k++) begin
            @(negedge clk);
            if ({bout[1], brel[1], blvl[1]} !== 3'b000) bad++;
        end
        nbin[1] = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if ({bout[1], brel[1], blvl[1]} !== 3'b000) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++; $display("FAIL glitch_reject got %0d active cycles required 0", bad);
        end
    endtask

    task automatic test_auto_repeat;
        int pulse_at[6];
        int n, post_b, post_r;
        int gap_req[5];
        gap_req = '{RD * TD, RP * TD, RP * TD, RP * TD, RP * TD};
        @(negedge clk);
        rpt_en[2] = 1'b1;
        nbin[2]   = 1'b0;
        n = 0;
        for (int k = 1; k <= 200 && n < 6; k++) begin
            @(negedge clk);
            if (bout[2] === 1'b1) begin pulse_at[n] = k; n++; end
        end
        nbin[2] = 1'b1;
        vectors++;
        if (n !== 6) begin
            miscompares++; $display("FAIL repeat_count got %0d pulses required 6", n);
        end else begin
            for (int g = 0; g < 5; g++) begin
                vectors++;
                if (pulse_at[g + 1] - pulse_at[g] !== gap_req[g]) begin
                    miscompares++;
                    $display("FAIL repeat_gap%0d got %0d cycles required %0d", g,
                             pulse_at[g + 1] - pulse_at[g], gap_req[g]);
                end
            end
        end
        post_b = 0; post_r = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bout[2] === 1'b1) post_b++;
            if (brel[2] === 1'b1) post_r++;
        end
        vectors++;
        if ({post_b, post_r} !== {32'd0, 32'd1}) begin
            miscompares++;
            $display("FAIL repeat_release got bout=%0d brel=%0d required 0 and 1", post_b, post_r);
        end
    endtask

    task automatic test_simultaneous_reset;
        bit seen;
        int rel_n, at;
        @(negedge clk);
        nbin[0] = 1'b0;
        nbin[2] = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bout[0] === 1'b1 || bout[2] === 1'b1) begin
                seen = 1;
                vectors++;
                if ({bout[2], bout[0]} !== 2'b11) begin
                    miscompares++;
                    $display("FAIL simul_press got %b required 11", {bout[2], bout[0]});
                end
            end
        end
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL simul_press got no pulse required 11");
        end
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bout[2] === 1'b1) seen = 1;
        end
        vectors++;
        if (!seen) begin
            miscompares++; $display("FAIL enter_repeat got no repeat pulse required 1");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({bout, brel, blvl} !== '0) begin
            miscompares++;
            $display("FAIL midop_reset got %b required 0", {bout, brel, blvl});
        end
        rel_n = 0; at = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (|brel) rel_n++;
            if (bout[0] === 1'b1 && bout[2] === 1'b1 && at < 0) at = k;
        end
        vectors++;
        if (rel_n !== 0) begin
            miscompares++; $display("FAIL no_release_on_reset got %0d required 0", rel_n);
        end
        vectors++;
        if (at !== DP * TD) begin
            miscompares++;
            $display("FAIL held_after_reset got %0d cycles required %0d", at, DP * TD);
        end
        @(negedge clk);
        nbin = '1;
        rpt_en = '0;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_tick_div1;
        logic [2:0] obs;
        @(negedge clk);
        nbin1[0] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            obs[k - 1] = bout1[0];
            if (k == 2) begin
                vectors++;
                if (blvl1[0] !== 1'b1) begin
                    miscompares++; $display("FAIL div1_blvl got %b required 1", blvl1[0]);
                end
            end
        end
        vectors++;
        if (obs !== 3'b010) begin
            miscompares++; $display("FAIL div1_press got %b required 010", obs);
        end
        nbin1[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            obs[k - 1] = brel1[0];
        end
        vectors++;
        if (obs !== 3'b010) begin
            miscompares++; $display("FAIL div1_release got %b required 010", obs);
        end
    endtask

    initial begin
        rst     = 1'b1;
        nbin    = '1;
        rpt_en  = '0;
        nbin1   = '1;
        rpt_en1 = '0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_auto_repeat();
        test_simultaneous_reset();
        test_tick_div1();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
